// File: rtl/calc_port_responder.sv
// Single-port responder for the calculator request/response protocol.
// Optional rotate commands (cmd 3/4) are enabled by defining CALC_ROTATE_EN.
module calc_port_responder #(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req_cmd_in,
  input  logic [31:0] req_data_in,
  output logic [1:0]  out_resp,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        req_dropped
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OPND2 = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [1:0] RESP_NONE    = 2'b00;
  localparam logic [1:0] RESP_OK      = 2'b01;
  localparam logic [1:0] RESP_OVF     = 2'b10;
  localparam logic [1:0] RESP_INVALID = 2'b11;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [3:0]  cmd_r;
  logic [31:0] op1_r;
  logic [1:0]  res_resp;
  logic [31:0] res_data;

  logic [32:0] sum;
  logic [31:0] shamt;
  logic [1:0]  calc_resp;
  logic [31:0] calc_data;
`ifdef CALC_ROTATE_EN
  logic [31:0] rot_amt;
`endif

  // Result is computed while operand2 is still on req_data_in.
  always_comb begin
    sum       = {1'b0, op1_r} + {1'b0, req_data_in};
    shamt     = 32'(req_data_in[SHAMT_W-1:0]);
    calc_resp = RESP_INVALID;
    calc_data = '0;
`ifdef CALC_ROTATE_EN
    rot_amt   = shamt & 32'd31;
`endif
    case (cmd_r)
      4'd1: begin
        if (sum[32]) begin
          calc_resp = RESP_OVF;
        end else begin
          calc_resp = RESP_OK;
          calc_data = sum[31:0];
        end
      end
      4'd2: begin
        if (req_data_in > op1_r) begin
          calc_resp = RESP_OVF;
        end else begin
          calc_resp = RESP_OK;
          calc_data = op1_r - req_data_in;
        end
      end
      4'd5: begin
        calc_resp = RESP_OK;
        calc_data = op1_r << shamt;
      end
      4'd6: begin
        calc_resp = RESP_OK;
        calc_data = op1_r >> shamt;
      end
`ifdef CALC_ROTATE_EN
      4'd3: begin
        calc_resp = RESP_OK;
        calc_data = (op1_r << rot_amt) | (op1_r >> (32'd32 - rot_amt));
      end
      4'd4: begin
        calc_resp = RESP_OK;
        calc_data = (op1_r >> rot_amt) | (op1_r << (32'd32 - rot_amt));
      end
`endif
      default: begin
        calc_resp = RESP_INVALID;
        calc_data = '0;
      end
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      cmd_r       <= '0;
      op1_r       <= '0;
      res_resp    <= RESP_NONE;
      res_data    <= '0;
      out_resp    <= RESP_NONE;
      out_data    <= '0;
      req_dropped <= 1'b0;
    end else begin
      out_resp <= RESP_NONE;
      out_data <= '0;
      case (state)
        // The response cycle doubles as IDLE so back-to-back requests are accepted.
        ST_IDLE, ST_RESP: begin
          if (req_cmd_in != '0) begin
            cmd_r <= req_cmd_in;
            op1_r <= req_data_in;
            state <= ST_OPND2;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_OPND2: begin
          if (req_cmd_in != '0) req_dropped <= 1'b1;
          res_resp <= calc_resp;
          res_data <= calc_data;
          cnt      <= CNT_INIT;
          if (LATENCY == 1) begin
            out_resp <= calc_resp;
            out_data <= calc_data;
            state    <= ST_RESP;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (req_cmd_in != '0) req_dropped <= 1'b1;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            out_resp <= res_resp;
            out_data <= res_data;
            state    <= ST_RESP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_OPND2) || (state == ST_WAIT);

endmodule

// File: tb/tb_calc_port_responder.sv
// Scoreboard bench for calc_port_responder: driver pushes expected responses,
// a negedge monitor pops and compares value and arrival cycle.
module tb_calc_port_responder;
  localparam int unsigned LAT = 3;
  localparam int unsigned SW  = 5;

  logic        c_clk;
  logic        reset;
  logic [3:0]  req_cmd_in;
  logic [31:0] req_data_in;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic        busy;
  logic        req_dropped;

  calc_port_responder #(.LATENCY(LAT), .SHAMT_W(SW)) dut (
    .c_clk(c_clk), .reset(reset), .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
    .out_resp(out_resp), .out_data(out_data), .busy(busy), .req_dropped(req_dropped)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  int cyc = 0;
  always @(posedge c_clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sbq[$];

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: result straight from the arithmetic rules.
  function automatic logic [33:0] model(input logic [3:0] cmd, input logic [31:0] a,
                                        input logic [31:0] b);
    longint unsigned s;
    int unsigned sh;
    int unsigned k;
    logic [1:0]  r;
    logic [31:0] d;
    sh = b % (32'd1 << SW);
    k  = sh % 32;
    r  = 2'b11;
    d  = '0;
    case (cmd)
      4'd1: begin
        s = a;
        s = s + b;
        if (s > 64'hFFFF_FFFF) r = 2'b10;
        else begin r = 2'b01; d = s[31:0]; end
      end
      4'd2: begin
        if (b > a) r = 2'b10;
        else begin r = 2'b01; d = a - b; end
      end
      4'd5: begin r = 2'b01; d = (sh >= 32) ? 32'd0 : a << sh; end
      4'd6: begin r = 2'b01; d = (sh >= 32) ? 32'd0 : a >> sh; end
`ifdef CALC_ROTATE_EN
      4'd3: begin r = 2'b01; d = (k == 0) ? a : ((a << k) | (a >> (32 - k))); end
      4'd4: begin r = 2'b01; d = (k == 0) ? a : ((a >> k) | (a << (32 - k))); end
`endif
      default: begin r = 2'b11; d = '0; end
    endcase
    return {r, d};
  endfunction

  always @(negedge c_clk) begin
    exp_t e;
    if (!reset) begin
      if (out_resp != 2'b00) begin
        if (sbq.size() == 0) begin
          check("unexpected_resp", {30'd0, out_resp}, 32'd0);
        end else begin
          e = sbq.pop_front();
          check("resp", {30'd0, out_resp}, {30'd0, e.resp});
          check("data", out_data, e.data);
          check("resp_cycle", cyc, e.due);
        end
      end else begin
        check("idle_data", out_data, 32'd0);
        if (sbq.size() > 0 && sbq[0].due < cyc) begin
          e = sbq.pop_front();
          check("missing_resp", cyc, e.due);
        end
      end
    end
  end

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic send(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                      input int gap);
    logic [33:0] m;
    exp_t e;
    req_cmd_in  = cmd;
    req_data_in = a;
    tick();
    check("busy", {31'd0, busy}, 32'd1);
    req_cmd_in  = 4'd0;
    req_data_in = b;
    m      = model(cmd, a, b);
    e.resp = m[33:32];
    e.data = m[31:0];
    e.due  = cyc + LAT;
    sbq.push_back(e);
    tick();
    req_data_in = $urandom;
    repeat (gap) tick();
  endtask

  initial begin
    int cmd;
    logic [31:0] a, b;
    int waited;
    reset       = 1'b1;
    req_cmd_in  = 4'd0;
    req_data_in = '0;
    tick();
    repeat (6) tick();
    reset = 1'b0;
    check("rst_resp", {30'd0, out_resp}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dropped", {31'd0, req_dropped}, 32'd0);
    req_data_in = 32'h64;
    repeat (3) tick();
    check("noop_busy", {31'd0, busy}, 32'd0);

    send(4'd1, 32'h64, 32'h27, LAT + 1);
    send(4'd1, 32'hFFFF_FFFF, 32'd1, LAT + 1);
    send(4'd2, 32'h22, 32'h23, LAT + 1);
    send(4'd2, 32'd5, 32'd2, LAT + 1);
    send(4'd5, 32'd3, 32'h22, LAT + 1);
    send(4'd6, 32'h0C, 32'd2, LAT + 1);
    send(4'd9, 32'd1, 32'd1, LAT + 1);
    send(4'd3, 32'h8000_0001, 32'd1, LAT + 1);
    send(4'd4, 32'h8000_0001, 32'd1, LAT + 1);

    // Command in WAIT is discarded and flagged.
    send(4'd1, 32'd10, 32'd20, 0);
    req_cmd_in  = 4'd1;
    req_data_in = 32'h1234;
    tick();
    req_cmd_in = 4'd0;
    repeat (LAT + 2) tick();
    check("dropped_set", {31'd0, req_dropped}, 32'd1);

    // Back-to-back: second command presented in the response cycle.
    send(4'd2, 32'd100, 32'd1, LAT - 1);
    send(4'd1, 32'd7, 32'd8, LAT + 1);
    check("dropped_sticky", {31'd0, req_dropped}, 32'd1);

    // Reset while in WAIT aborts the request silently.
    req_cmd_in  = 4'd1;
    req_data_in = 32'd5;
    tick();
    req_cmd_in  = 4'd0;
    req_data_in = 32'd6;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_resp", {30'd0, out_resp}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_dropped", {31'd0, req_dropped}, 32'd0);
    repeat (LAT + 2) tick();

    for (int i = 0; i < 200; i++) begin
      cmd = $urandom_range(0, 15);
      case ($urandom_range(0, 3))
        0: a = 32'hFFFF_FFFF;
        1: a = $urandom_range(0, 40);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: b = 32'hFFFF_FFFF;
        1: b = $urandom_range(0, 40);
        default: b = $urandom;
      endcase
      if (cmd == 0) begin
        req_data_in = a;
        tick();
      end else begin
        send(4'(cmd), a, b, $urandom_range(LAT - 1, LAT + 1));
      end
    end

    waited = 0;
    while (sbq.size() > 0 && waited < 50) begin
      tick();
      waited++;
    end
    check("drain", sbq.size(), 32'd0);
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
